instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_timer.sv | 39 +++
 rtl/instruction_fetch.sv | 158 +++++++++++++++
 tb/tb_instruction_fetch.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and the fetch state encoding for the CPU front end.
package cpu_pkg;

  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Counts cycles spent waiting on memory; expired is high during the
// TIMEOUT-th enabled cycle so the owner can bail out on that edge.
module fetch_timer import cpu_pkg::*; #(
  parameter int TIMEOUT = cpu_pkg::TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             at_limit;

  assign at_limit = (count_reg == CNT_W'(TIMEOUT - 1));
  assign expired  = enable && at_limit;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && !at_limit) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: issues one read per PC value,
// holds the result in ir until decode accepts it, and drops fetches on jumps.
module instruction_fetch import cpu_pkg::*; #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int TIMEOUT = cpu_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [DATA_W-1:0] pc,
  input  logic              jump,
  output logic              pc_enable,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              mem_err
);

  fetch_state_t state_reg, state_next;

  logic              flush_reg,     flush_next;
  logic              mem_req_reg,   mem_req_next;
  logic [DATA_W-1:0] mem_addr_reg,  mem_addr_next;
  logic [DATA_W-1:0] ir_reg,        ir_next;
  logic [DATA_W-1:0] ir_pc_reg,     ir_pc_next;
  logic              ir_valid_reg,  ir_valid_next;
  logic              pc_enable_reg, pc_enable_next;
  logic              mem_err_reg,   mem_err_next;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;
  logic drop_data;

  // A jump seen on the ack edge itself is treated like an earlier flush.
  assign drop_data    = flush_reg || jump;
  assign timer_enable = (state_reg == WAIT);
  assign timer_clear  = (state_next != WAIT);

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      flush_reg     <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      ir_reg        <= '0;
      ir_pc_reg     <= '0;
      ir_valid_reg  <= 1'b0;
      pc_enable_reg <= 1'b0;
      mem_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_reg     <= flush_next;
      mem_req_reg   <= mem_req_next;
      mem_addr_reg  <= mem_addr_next;
      ir_reg        <= ir_next;
      ir_pc_reg     <= ir_pc_next;
      ir_valid_reg  <= ir_valid_next;
      pc_enable_reg <= pc_enable_next;
      mem_err_reg   <= mem_err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (fetch_en && !jump) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_next = drop_data ? IDLE : FULL;
        end else if (timer_expired) begin
          state_next = IDLE;
        end
      end
      FULL: begin
        if (ir_ready || jump) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    flush_next     = flush_reg;
    mem_req_next   = mem_req_reg;
    mem_addr_next  = mem_addr_reg;
    ir_next        = ir_reg;
    ir_pc_next     = ir_pc_reg;
    ir_valid_next  = ir_valid_reg;
    pc_enable_next = 1'b0;
    mem_err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fetch_en && !jump) begin
          mem_req_next  = 1'b1;
          mem_addr_next = pc;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          flush_next   = 1'b0;
          if (!drop_data) begin
            ir_next        = mem_rdata;
            ir_pc_next     = mem_addr_reg;
            ir_valid_next  = 1'b1;
            pc_enable_next = 1'b1;
          end
        end else if (timer_expired) begin
          mem_req_next = 1'b0;
          mem_err_next = 1'b1;
          flush_next   = 1'b0;
        end else if (jump) begin
          flush_next = 1'b1;
        end
      end
      FULL: begin
        if (ir_ready || jump) begin
          ir_valid_next = 1'b0;
        end
      end
      default: begin
        mem_req_next  = 1'b0;
        ir_valid_next = 1'b0;
        flush_next    = 1'b0;
      end
    endcase
  end

  assign pc_enable = pc_enable_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_req   = mem_req_reg;
  assign ir        = ir_reg;
  assign ir_pc     = ir_pc_reg;
  assign ir_valid  = ir_valid_reg;
  assign mem_err   = mem_err_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: each task drives one scenario and
// checks outputs 1 time unit after the rising edge.
module tb_instruction_fetch;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fetch_en = 1'b0;
  logic         jump = 1'b0;
  logic         mem_ack = 1'b0;
  logic         ir_ready = 1'b0;
  logic [W-1:0] pc = '0;
  logic [W-1:0] mem_rdata = '0;
  logic         pc_enable, mem_req, ir_valid, mem_err;
  logic [W-1:0] mem_addr, ir, ir_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.DATA_W(16), .TIMEOUT(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_en  (fetch_en),
    .pc        (pc),
    .jump      (jump),
    .pc_enable (pc_enable),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .mem_err   (mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, pc_enable, ir_valid, mem_err, mem_addr, ir, ir_pc} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: req=%b pce=%b val=%b err=%b addr=%h ir=%h ir_pc=%h, want all 0",
               mem_req, pc_enable, ir_valid, mem_err, mem_addr, ir, ir_pc);
    end
    tick();
    tick();
    @(negedge clk) rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      mem_ack = i[0];
      tick();
      if (mem_req !== 1'b0 || pc_enable !== 1'b0 || ir_valid !== 1'b0 || mem_err !== 1'b0) bad++;
    end
    mem_ack = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL reset_idle: %0d cycles with activity, want 0", bad);
    end
    $display("txn reset/idle done");
  endtask

  task automatic test_zero_wait();
    pc = 16'h0010;
    fetch_en = 1'b1;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0010 || ir_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL zw_req: req=%b addr=%h val=%b, want 1/0010/0", mem_req, mem_addr, ir_valid);
    end
    mem_ack = 1'b1;
    mem_rdata = 16'hA5A5;
    tick();
    n_cmp++;
    if (mem_req !== 1'b0 || ir !== 16'hA5A5 || ir_pc !== 16'h0010 || ir_valid !== 1'b1 || pc_enable !== 1'b1) begin
      n_bad++;
      $display("FAIL zw_data: req=%b ir=%h ir_pc=%h val=%b pce=%b, want 0/a5a5/0010/1/1",
               mem_req, ir, ir_pc, ir_valid, pc_enable);
    end
    $display("txn fetch addr=%h ir=%h", ir_pc, ir);
    mem_ack = 1'b0;
    pc = pc + 1'b1;
    tick();
    n_cmp++;
    if (pc_enable !== 1'b0 || ir_valid !== 1'b1 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL zw_pulse: pce=%b val=%b req=%b, want 0/1/0", pc_enable, ir_valid, mem_req);
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    n_cmp++;
    if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL zw_consume: val=%b req=%b, want 0/0", ir_valid, mem_req);
    end
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0011) begin
      n_bad++;
      $display("FAIL zw_next_addr: req=%b addr=%h, want 1/0011", mem_req, mem_addr);
    end
    fetch_en = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'h0000;
    tick();
    mem_ack = 1'b0;
    pc = pc + 1'b1;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    $display("txn fetch addr=0011 drained");
  endtask

  task automatic test_wait_state();
    int bad;
    pc = 16'h0020;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_req !== 1'b1 || mem_addr !== 16'h0020 || pc_enable !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL ws_stable: %0d unstable wait cycles, want 0", bad);
    end
    mem_ack = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b0 || ir !== 16'hBEEF || ir_pc !== 16'h0020 || pc_enable !== 1'b1) begin
      n_bad++;
      $display("FAIL ws_data: req=%b ir=%h ir_pc=%h pce=%b, want 0/beef/0020/1", mem_req, ir, ir_pc, pc_enable);
    end
    $display("txn fetch addr=%h ir=%h", ir_pc, ir);
    pc = pc + 1'b1;
    bad = 0;
    tick();
    if (pc_enable !== 1'b0) bad++;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    if (pc_enable !== 1'b0 || ir_valid !== 1'b0) bad++;
    tick();
    if (mem_req !== 1'b0) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL ws_after: %0d bad cycles (extra pulse or restart), want 0", bad);
    end
  endtask

  task automatic test_flush();
    pc = 16'h0030;
    fetch_en = 1'b1;
    tick();
    jump = 1'b1;
    pc = 16'h003F;
    tick();
    jump = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0030) begin
      n_bad++;
      $display("FAIL fl_hold: req=%b addr=%h, want 1/0030", mem_req, mem_addr);
    end
    tick();
    mem_ack = 1'b1;
    mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0;
    n_cmp++;
    if (ir_valid !== 1'b0 || pc_enable !== 1'b0 || mem_req !== 1'b0 || ir !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL fl_discard: val=%b pce=%b req=%b ir=%h, want 0/0/0/beef", ir_valid, pc_enable, mem_req, ir);
    end
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h003F) begin
      n_bad++;
      $display("FAIL fl_refetch: req=%b addr=%h, want 1/003f", mem_req, mem_addr);
    end
    fetch_en = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    n_cmp++;
    if (ir_valid !== 1'b1 || ir !== 16'h5555 || ir_pc !== 16'h003F || pc_enable !== 1'b1) begin
      n_bad++;
      $display("FAIL fl_after: val=%b ir=%h ir_pc=%h pce=%b, want 1/5555/003f/1", ir_valid, ir, ir_pc, pc_enable);
    end
    $display("txn flush then fetch addr=%h ir=%h", ir_pc, ir);
    pc = pc + 1'b1;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad;
    pc = 16'h0040;
    fetch_en = 1'b1;
    tick();
    mem_ack = 1'b1;
    mem_rdata = 16'hC0DE;
    tick();
    mem_ack = 1'b0;
    pc = pc + 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ir !== 16'hC0DE || ir_valid !== 1'b1 || mem_req !== 1'b0 || pc_enable !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL bp_stall: %0d bad stall cycles, want 0", bad);
    end
    ir_ready = 1'b1;
    jump = 1'b1;
    pc = 16'h0100;
    tick();
    ir_ready = 1'b0;
    jump = 1'b0;
    n_cmp++;
    if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_jump_ready: val=%b req=%b, want 0/0", ir_valid, mem_req);
    end
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin
      n_bad++;
      $display("FAIL bp_idle_fetch: req=%b addr=%h, want 1/0100", mem_req, mem_addr);
    end
    $display("txn backpressure consumed ir=c0de, refetch addr=%h", mem_addr);
    fetch_en = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    pc = pc + 1'b1;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
  endtask

  task automatic test_wrap();
    pc = 16'hFFFF;
    fetch_en = 1'b1;
    tick();
    mem_ack = 1'b1;
    mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    n_cmp++;
    if (ir !== 16'h7777 || ir_pc !== 16'hFFFF || pc_enable !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_fetch: ir=%h ir_pc=%h pce=%b, want 7777/ffff/1", ir, ir_pc, pc_enable);
    end
    $display("txn fetch addr=%h ir=%h", ir_pc, ir);
    pc = pc + 1'b1;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_next: req=%b addr=%h, want 1/0000", mem_req, mem_addr);
    end
    fetch_en = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    pc = pc + 1'b1;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int early;
    pc = 16'h0200;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    early = 0;
    for (int k = 1; k < 255; k++) begin
      tick();
      if (mem_req !== 1'b1 || mem_err !== 1'b0 || pc_enable !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_bad++;
      $display("FAIL to_wait: %0d bad cycles before timeout, want 0", early);
    end
    tick();
    n_cmp++;
    if (mem_err !== 1'b1 || mem_req !== 1'b0 || pc_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL to_fire: err=%b req=%b pce=%b, want 1/0/0", mem_err, mem_req, pc_enable);
    end
    tick();
    n_cmp++;
    if (mem_err !== 1'b0 || mem_req !== 1'b0 || ir_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL to_pulse: err=%b req=%b val=%b, want 0/0/0", mem_err, mem_req, ir_valid);
    end
    $display("txn timeout addr=0200");
  endtask

  task automatic test_reset_in_wait();
    pc = 16'h0300;
    fetch_en = 1'b1;
    tick();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || mem_addr !== 16'h0000 || ir !== 16'h0000) begin
      n_bad++;
      $display("FAIL rw_async: req=%b addr=%h ir=%h, want 0/0000/0000", mem_req, mem_addr, ir);
    end
    fetch_en = 1'b0;
    mem_ack = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_cmp++;
    if (ir_valid !== 1'b0 || pc_enable !== 1'b0 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL rw_late_ack: val=%b pce=%b req=%b, want 0/0/0", ir_valid, pc_enable, mem_req);
    end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0300) begin
      n_bad++;
      $display("FAIL rw_first_req: req=%b addr=%h, want 1/0300", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    $display("txn reset during wait recovered");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_state();
    test_flush();
    test_backpressure();
    test_wrap();
    test_timeout();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
